wb_vmon_multi_monitor: RTL



---
 rtl/wb_vmon_multi_monitor.sv | 112 +++++++++++
 1 files changed

// File: rtl/wb_vmon_multi_monitor.sv
// Passive Wishbone snooper: captures acked writes to N equally spaced
// monitor registers into a FWFT FIFO drained over valid/ready.
module wb_vmon_multi_monitor #(
    parameter int unsigned WB_ADDR_WIDTH  = 32,
    parameter int unsigned WB_DATA_WIDTH  = 32,
    parameter int unsigned N_CHANNELS     = 4,
    parameter logic [WB_ADDR_WIDTH-1:0] BASE_ADDRESS = 'h6000_1000,
    parameter int unsigned CHANNEL_STRIDE = 'h10,
    parameter int unsigned FIFO_DEPTH     = 8,
    localparam int unsigned SW = WB_DATA_WIDTH / 8,
    localparam int unsigned CW = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1,
    localparam int unsigned LW = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [WB_ADDR_WIDTH-1:0] ADR,
    input  logic [WB_DATA_WIDTH-1:0] DAT_W,
    input  logic                     CYC,
    input  logic                     STB,
    input  logic                     WE,
    input  logic                     ACK,
    input  logic                     ERR,
    input  logic [SW-1:0]            SEL,
    input  logic [N_CHANNELS-1:0]    ch_en,
    output logic                     msg_valid,
    input  logic                     msg_ready,
    output logic [CW-1:0]            msg_chan,
    output logic [WB_DATA_WIDTH-1:0] msg_data,
    output logic [SW-1:0]            msg_sel,
    output logic [LW-1:0]            level,
    output logic [15:0]              overflow_cnt
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned SB = $clog2(CHANNEL_STRIDE);
    localparam int unsigned EW = CW + WB_DATA_WIDTH + SW;
    localparam logic [WB_ADDR_WIDTH:0] SPAN =
        (WB_ADDR_WIDTH + 1)'(N_CHANNELS * CHANNEL_STRIDE);
    localparam logic [WB_ADDR_WIDTH-1:0] SMASK =
        WB_ADDR_WIDTH'(CHANNEL_STRIDE - 1);

    logic [EW-1:0]            mem_q [FIFO_DEPTH];
    logic [PW-1:0]            rd_q, rd_d, wr_q, wr_d;
    logic [LW-1:0]            level_q, level_d, remain;
    logic [15:0]              ovf_q, ovf_d;
    logic [EW-1:0]            head_q, head_d, entry;
    logic [WB_ADDR_WIDTH-1:0] off;
    logic [CW-1:0]            chan;
    logic                     beat, in_range, aligned, en_bit;
    logic                     hit, full, pop, push, drop;

    // Modular subtraction makes addresses below the base miss naturally
    assign off      = ADR - BASE_ADDRESS;
    assign chan     = CW'(off >> SB);
    assign in_range = {1'b0, off} < SPAN;
    assign aligned  = (off & SMASK) == '0;
    assign beat     = CYC & STB & WE & ACK & ~ERR;
    assign entry    = {chan, DAT_W, SEL};

    always_comb begin
        en_bit = 1'b0;
        for (int i = 0; i < int'(N_CHANNELS); i++) begin
            if (chan == CW'(i)) en_bit = ch_en[i];
        end
    end

    always_comb begin
        hit     = beat & in_range & aligned & en_bit;
        full    = level_q == LW'(FIFO_DEPTH);
        pop     = msg_valid & msg_ready;
        push    = hit & (~full | pop);
        drop    = hit & full & ~pop;
        rd_d    = rd_q + PW'(pop);
        wr_d    = wr_q + PW'(push);
        level_d = level_q;
        if (push & ~pop) level_d = level_q + 1'b1;
        else if (pop & ~push) level_d = level_q - 1'b1;
        ovf_d = ovf_q;
        if (drop && ovf_q != 16'hFFFF) ovf_d = ovf_q + 16'd1;
        // Head register tracks the oldest entry left after this edge
        remain = level_q - LW'(pop);
        head_d = head_q;
        if (remain != '0) head_d = mem_q[rd_d];
        else if (push) head_d = entry;
    end

    always_ff @(posedge clk_i) begin
        if (push && !rst_i) mem_q[wr_q] <= entry;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_q    <= '0;
            wr_q    <= '0;
            level_q <= '0;
            ovf_q   <= '0;
            head_q  <= '0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
            head_q  <= head_d;
        end
    end

    assign msg_valid    = level_q != '0;
    assign level        = level_q;
    assign overflow_cnt = ovf_q;
    assign {msg_chan, msg_data, msg_sel} = head_q;

endmodule
